// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of the signals exchanged between the pipeline and the hazard unit.
//
//   Pipeline -> hazard unit
//     id_rs1, id_rs2          source registers of the instruction in ID
//     id_use_rs1, id_use_rs2  ID instruction actually reads rs1 / rs2
//     ex_rd, ex_mem_read      destination and load flag of the instruction in EX
//     mem_branch_taken        (branch & alu_zero) | jump in MEM
//     mem_req, mem_ready      data-memory access in MEM and its completion
//   Hazard unit -> pipeline
//     stall_pc/if_id/id_ex/ex_mem      hold PC / pipeline register
//     flush_if_id/id_ex/ex_mem/mem_wb  insert bubble into pipeline register
//     pc_redirect                      PC loads the branch target
//     mem_timeout                      one-cycle pulse on an abandoned access
//     bubble_cnt                       saturating count of bubble cycles
//
// master: the pipeline side.  slave: the hazard unit.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int REG_SEL = 5
);
   logic [REG_SEL-1:0] id_rs1;
   logic [REG_SEL-1:0] id_rs2;
   logic               id_use_rs1;
   logic               id_use_rs2;
   logic [REG_SEL-1:0] ex_rd;
   logic               ex_mem_read;
   logic               mem_branch_taken;
   logic               mem_req;
   logic               mem_ready;

   logic               stall_pc;
   logic               stall_if_id;
   logic               stall_id_ex;
   logic               stall_ex_mem;
   logic               flush_if_id;
   logic               flush_id_ex;
   logic               flush_ex_mem;
   logic               flush_mem_wb;
   logic               pc_redirect;
   logic               mem_timeout;
   logic [15:0]        bubble_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             mem_branch_taken, mem_req, mem_ready,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             pc_redirect, mem_timeout, bubble_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             mem_branch_taken, mem_req, mem_ready,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             pc_redirect, mem_timeout, bubble_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard control unit for a 5-stage pipeline (IF/ID/EX/MEM/WB).
// Resolves three hazard sources, in priority order:
//   1. data-memory wait  : freeze the whole pipe, bubble into MEM/WB
//   2. taken branch/jump : redirect PC, squash IF/ID, ID/EX, EX/MEM
//   3. load-use          : hold PC and IF/ID, bubble into ID/EX
// A memory access that does not complete within MEM_TIMEOUT wait cycles is
// abandoned and reported with a one-cycle mem_timeout pulse.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous reset, active low
//   hz   hazard_ctrl_if.slave (pipeline status in, stall/flush controls out)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int NUM_REGS    = 32,
   parameter int REG_SEL     = $clog2(NUM_REGS),
   parameter int MEM_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // ID source operand depends on the EX destination.
   function automatic logic src_hit(input logic               use_src,
                                    input logic [REG_SEL-1:0] rs,
                                    input logic [REG_SEL-1:0] rd);
      return use_src && (rs == rd);
   endfunction

   state_t      state, state_nxt;
   logic [7:0]  wcnt, wcnt_nxt;
   logic [15:0] bubble_cnt;

   logic load_use;
   logic redirect;
   logic mem_wait;
   logic eval;          // branch / load-use arbitration is live this cycle
   logic bubble;

   logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
   logic pc_redirect, mem_timeout;

   // x0 is hard-wired zero, so a load into it never creates a dependency.
   assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                     (src_hit(hz.id_use_rs1, hz.id_rs1, hz.ex_rd) ||
                      src_hit(hz.id_use_rs2, hz.id_rs2, hz.ex_rd));
   assign redirect = hz.mem_branch_taken;
   assign mem_wait = hz.mem_req && !hz.mem_ready;

   always_comb begin
      state_nxt    = state;
      wcnt_nxt     = wcnt;
      eval         = 1'b0;
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      flush_mem_wb = 1'b0;
      pc_redirect  = 1'b0;
      mem_timeout  = 1'b0;

      if (!rst) begin
         // Squash everything while reset is held; any pending access is
         // simply dropped, never reported as a timeout.
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_ex_mem = 1'b1;
         flush_mem_wb = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_wait) begin
                  stall_pc     = 1'b1;
                  stall_if_id  = 1'b1;
                  stall_id_ex  = 1'b1;
                  stall_ex_mem = 1'b1;
                  flush_mem_wb = 1'b1;
                  state_nxt    = MEM_WAIT;
                  wcnt_nxt     = 8'd1;
               end else begin
                  eval = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (hz.mem_ready) begin
                  // Access retires now; the pipe moves again this cycle.
                  state_nxt = RUN;
                  wcnt_nxt  = 8'd0;
                  eval      = 1'b1;
               end else if (wcnt >= TMO) begin
                  mem_timeout = 1'b1;
                  state_nxt   = RUN;
                  wcnt_nxt    = 8'd0;
                  eval        = 1'b1;
               end else begin
                  stall_pc     = 1'b1;
                  stall_if_id  = 1'b1;
                  stall_id_ex  = 1'b1;
                  stall_ex_mem = 1'b1;
                  flush_mem_wb = 1'b1;
                  wcnt_nxt     = wcnt + 8'd1;
               end
            end
            default: begin
               state_nxt = RUN;
               wcnt_nxt  = 8'd0;
            end
         endcase

         if (eval) begin
            if (redirect) begin
               // Younger instructions are on the wrong path; the load-use
               // stall would be pointless since ID is squashed anyway.
               pc_redirect  = 1'b1;
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
            end else if (load_use) begin
               stall_pc    = 1'b1;
               stall_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end
         end
      end
   end

   assign bubble = eval && (redirect || load_use);

   // State, wait counter and bubble statistics
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RUN;
         wcnt       <= 8'd0;
         bubble_cnt <= 16'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (bubble) begin
            bubble_cnt <= sat_inc16(bubble_cnt);
         end
      end
   end

   assign hz.stall_pc     = stall_pc;
   assign hz.stall_if_id  = stall_if_id;
   assign hz.stall_id_ex  = stall_id_ex;
   assign hz.stall_ex_mem = stall_ex_mem;
   assign hz.flush_if_id  = flush_if_id;
   assign hz.flush_id_ex  = flush_id_ex;
   assign hz.flush_ex_mem = flush_ex_mem;
   assign hz.flush_mem_wb = flush_mem_wb;
   assign hz.pc_redirect  = pc_redirect;
   assign hz.mem_timeout  = mem_timeout;
   assign hz.bubble_cnt   = bubble_cnt;

endmodule
